// File: rtl/fifo_burst_drain.sv
// Read-side drain for the frame-write prefetch FIFO. It waits for a full burst to be
// buffered, issues one address command, then streams that burst onto the write-data channel.
module fifo_burst_drain #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned FIFO_DEPTH  = 2048,
    parameter int unsigned ADDR_W      = 28,
    parameter int unsigned BURST_LEN   = 64,
    parameter int unsigned FRAME_WORDS = 921600,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_wr_fire,
    output logic              fifo_rd_en,
    input  logic              fifo_rd_vld,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              frame_start,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [7:0]        cmd_len,
    output logic              wdata_valid,
    input  logic              wdata_ready,
    output logic [DATA_W-1:0] wdata,
    output logic              wdata_last,
    output logic              busy
);

    localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned BPF    = FRAME_WORDS / BURST_LEN;
    localparam int unsigned BCNT_W = $clog2(BPF + 1);

    localparam logic [LVL_W-1:0]  LVL_BURST = LVL_W'(BURST_LEN);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BPF - 1);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BURST_LEN * DATA_W / 8);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_DATA
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LVL_W-1:0]    r_level;
    logic [BEAT_W-1:0]   r_beat;
    logic [BCNT_W-1:0]   r_bcnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_pend;

    logic                w_cmd_valid;
    logic                w_wdata_valid;
    logic                w_pop;
    logic                w_beat_last;
    logic                w_last_acc;

    always_comb begin
        w_state_nxt   = r_state;
        w_cmd_valid   = 1'b0;
        w_wdata_valid = 1'b0;
        w_pop         = 1'b0;
        w_beat_last   = (r_beat == BEAT_LAST);
        w_last_acc    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_level >= LVL_BURST) begin
                    w_state_nxt = S_CMD;
                end
            end
            S_CMD: begin
                w_cmd_valid = 1'b1;
                if (cmd_ready) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_wdata_valid = fifo_rd_vld;
                w_pop         = fifo_rd_vld & wdata_ready;
                w_last_acc    = w_pop & w_beat_last;
                if (w_last_acc) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_level <= '0;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_level <= r_level + LVL_W'(fifo_wr_fire) - LVL_W'(w_pop);
            if (r_state == S_CMD && cmd_ready) begin
                r_beat <= '0;
            end else if (w_pop) begin
                r_beat <= r_beat + BEAT_W'(1);
            end
        end
    end

    // A frame restart is only applied in IDLE, so an issued command or in-flight burst keeps its address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= BASE_ADDR;
            r_bcnt <= '0;
            r_pend <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                r_pend <= 1'b0;
            end else if (frame_start) begin
                r_pend <= 1'b1;
            end

            if (r_state == S_IDLE && (r_pend || frame_start)) begin
                r_addr <= BASE_ADDR;
                r_bcnt <= '0;
            end else if (w_last_acc) begin
                if (r_bcnt == BCNT_LAST) begin
                    r_addr <= BASE_ADDR;
                    r_bcnt <= '0;
                end else begin
                    r_addr <= r_addr + ADDR_STEP;
                    r_bcnt <= r_bcnt + BCNT_W'(1);
                end
            end
        end
    end

    assign fifo_rd_en  = w_pop;
    assign cmd_valid   = w_cmd_valid;
    assign cmd_addr    = r_addr;
    assign cmd_len     = 8'(BURST_LEN - 1);
    assign wdata_valid = w_wdata_valid;
    assign wdata       = fifo_rd_data;
    assign wdata_last  = w_wdata_valid & w_beat_last;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Scoreboard bench for fifo_burst_drain: a queue models the FIFO, stimulus pushes expected
// commands/beats, and a negedge monitor pops and compares on every accepted handshake.
`timescale 1ns/1ps
module tb_fifo_burst_drain;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 28;
    localparam int BURST  = 64;
    localparam int FRAME  = 192;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              fifo_wr_fire;
    logic              fifo_rd_en;
    logic              fifo_rd_vld;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              frame_start;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [7:0]        cmd_len;
    logic              wdata_valid;
    logic              wdata_ready = 1'b1;
    logic [DATA_W-1:0] wdata;
    logic              wdata_last;
    logic              busy;

    logic [DATA_W-1:0] wr_data;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              last;
    } beat_t;

    logic [DATA_W-1:0] fifo_q[$];
    beat_t             exp_beat[$];
    logic [ADDR_W-1:0] exp_cmd[$];

    int          errors = 0;
    int          checks = 0;
    int unsigned data_ctr = 0;
    int unsigned wr_idx = 0;
    bit          rdy_rand = 1'b0;

    always #5 clk = ~clk;

    fifo_burst_drain #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (2048),
        .ADDR_W     (ADDR_W),
        .BURST_LEN  (BURST),
        .FRAME_WORDS(FRAME),
        .BASE_ADDR  ('0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fifo_wr_fire(fifo_wr_fire),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_vld (fifo_rd_vld),
        .fifo_rd_data(fifo_rd_data),
        .frame_start (frame_start),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .wdata_last  (wdata_last),
        .busy        (busy)
    );

    // First-word-fall-through FIFO model
    assign fifo_rd_vld  = (fifo_q.size() != 0);
    assign fifo_rd_data = fifo_rd_vld ? fifo_q[0] : '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q.delete();
        end else begin
            if (fifo_rd_en && fifo_q.size() != 0) void'(fifo_q.pop_front());
            if (fifo_wr_fire) fifo_q.push_back(wr_data);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        logic [ADDR_W-1:0] a;
        beat_t             b;
        if (rst_n) begin
            check("level", 32'(dut.r_level), 32'(fifo_q.size()));
            check("rd_en", 32'(fifo_rd_en), 32'(wdata_valid & wdata_ready));
            if (cmd_valid && cmd_ready) begin
                if (exp_cmd.size() == 0) begin
                    check("cmd_unexpected", 32'(1), 32'(0));
                end else begin
                    a = exp_cmd.pop_front();
                    check("cmd_addr", 32'(cmd_addr), 32'(a));
                    check("cmd_len", 32'(cmd_len), 32'(BURST - 1));
                end
            end
            if (wdata_valid && wdata_ready) begin
                if (exp_beat.size() == 0) begin
                    check("beat_unexpected", 32'(1), 32'(0));
                end else begin
                    b = exp_beat.pop_front();
                    check("wdata", 32'(wdata), 32'(b.d));
                    check("wdata_last", 32'(wdata_last), 32'(b.last));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            wdata_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_words(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_wr_fire = 1'b1;
            wr_data      = DATA_W'(data_ctr);
            exp_beat.push_back({DATA_W'(data_ctr), 1'((wr_idx % BURST) == BURST - 1)});
            data_ctr++;
            wr_idx++;
            tick();
        end
        fifo_wr_fire = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_beat.size() != 0 || busy) && n < 2000) begin
            tick();
            n++;
        end
        check(name, 32'(n < 2000), 32'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'(0));
        check({tag, "_cmd_addr"}, 32'(cmd_addr), 32'(0));
        check({tag, "_cmd_len"}, 32'(cmd_len), 32'(BURST - 1));
        check({tag, "_wdata_valid"}, 32'(wdata_valid), 32'(0));
        check({tag, "_wdata_last"}, 32'(wdata_last), 32'(0));
        check({tag, "_rd_en"}, 32'(fifo_rd_en), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_level"}, 32'(dut.r_level), 32'(0));
    endtask

    initial begin
        int          n;
        bit          bad;
        int unsigned start;

        fifo_wr_fire = 1'b0;
        wr_data      = '0;
        frame_start  = 1'b0;
        cmd_ready    = 1'b0;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        // One burst at 0, next at 128
        cmd_ready = 1'b1;
        exp_cmd.push_back(28'd0);
        write_words(64);
        drain("drain_b0");
        exp_cmd.push_back(28'd128);
        write_words(64);
        drain("drain_b128");

        // 63 words: no command; 64th: command one cycle after level hits 64
        cmd_ready = 1'b0;
        write_words(63);
        bad = 1'b0;
        repeat (100) begin
            tick();
            if (cmd_valid) bad = 1'b1;
        end
        check("no_cmd_at_63", 32'(bad), 32'(0));
        write_words(1);
        check("cmd_lat_early", 32'(cmd_valid), 32'(0));
        tick();
        check("cmd_lat", 32'(cmd_valid), 32'(1));
        check("cmd_addr_256", 32'(cmd_addr), 32'(256));
        tick();
        check("cmd_addr_hold", 32'(cmd_addr), 32'(256));
        exp_cmd.push_back(28'd256);
        cmd_ready = 1'b1;
        drain("drain_b256");

        // Frame wrap to 0, then random backpressure with concurrent writes
        rdy_rand = 1'b1;
        exp_cmd.push_back(28'd0);
        exp_cmd.push_back(28'd128);
        write_words(128);
        drain("drain_rand");
        rdy_rand = 1'b0;

        exp_cmd.push_back(28'd256);
        write_words(64);
        drain("drain_b256_2");
        exp_cmd.push_back(28'd0);
        write_words(64);
        drain("drain_b0_2");

        // frame_start during burst at 128: that burst keeps 128, next command restarts at 0
        exp_cmd.push_back(28'd128);
        write_words(64);
        n = 0;
        while (!(busy && wdata_valid) && n < 200) begin
            tick();
            n++;
        end
        check("reach_data", 32'(n < 200), 32'(1));
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        drain("drain_fs");
        exp_cmd.push_back(28'd0);
        write_words(64);
        drain("drain_after_fs");

        // Reset mid-burst at beat 20
        exp_cmd.push_back(28'd128);
        start = data_ctr;
        write_words(64);
        n = 0;
        while (!(wdata_valid && wdata_ready && wdata == DATA_W'(start + 20)) && n < 300) begin
            tick();
            n++;
        end
        check("reach_beat20", 32'(n < 300), 32'(1));
        rst_n = 1'b0;
        #1;
        exp_beat.delete();
        exp_cmd.delete();
        wr_idx = 0;
        check_reset_outputs("midrst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_level", 32'(dut.r_level), 32'(0));
        write_words(63);
        bad = 1'b0;
        repeat (50) begin
            tick();
            if (cmd_valid) bad = 1'b1;
        end
        check("no_cmd_post_rst", 32'(bad), 32'(0));
        exp_cmd.push_back(28'd0);
        write_words(1);
        drain("drain_post_rst");

        check("cmd_queue_empty", 32'(exp_cmd.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
